seq_divider_8x8: RTL and testbench

Sequential restoring divider. It divides a 2W-bit dividend by a W-bit divisor and returns a W-bit quotient and a W-bit remainder. It is the inverse datapath of the 8×8 Vedic multiplier: a 16-bit product fed back with one of its factors recovers the other factor. Each trial subtraction is performed by a ripple chain of the existing `full_adder` cell, and one quotient bit is resolved per clock.

---
 rtl/vedic_pkg.sv | 20 ++
 rtl/full_adder.sv | 13 +
 rtl/trial_subtractor.sv | 29 ++
 rtl/seq_divider_8x8.sv | 122 ++++++++++++
 tb/tb_seq_divider_8x8.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier / restoring divider family:
// default operand width, FSM encodings and iteration-counter sizing.
package vedic_pkg;

   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold 0..W-1 with one spare bit of headroom.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int CNT_W = cnt_width(W_DEF);

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the multiplier and divider datapaths.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/trial_subtractor.sv
// (W+1)-bit ripple subtractor built from full_adder cells: minuend + ~subtrahend + 1.
// borrow_n is the final carry-out; high means minuend >= subtrahend.
module trial_subtractor import vedic_pkg::*; #(
   parameter int W = W_DEF
) (
   input  logic [W:0] minuend,
   input  logic [W:0] subtrahend,
   output logic [W:0] difference,
   output logic       borrow_n
);

   logic [W+1:0] carry;

   assign carry[0] = 1'b1;

   genvar i;
   for (i = 0; i <= W; i++) begin : g_fa
      full_adder u_fa (
         .a    (minuend[i]),
         .b    (~subtrahend[i]),
         .cin  (carry[i]),
         .sum  (difference[i]),
         .cout (carry[i+1])
      );
   end

   assign borrow_n = carry[W+1];

endmodule

// File: rtl/seq_divider_8x8.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit
// per clock. Error cases (divide by zero, quotient overflow) finish in one cycle.
module seq_divider_8x8 import vedic_pkg::*; #(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [W-1:0]   quotient,
   output logic [W-1:0]   remainder,
   output logic           div_by_zero,
   output logic           overflow
);

   localparam int CW = cnt_width(W);

   state_t        state;
   // Partial remainder is always < divisor between iterations, so W bits suffice;
   // the (W+1)-bit value only exists transiently after the shift.
   logic [W-1:0]  r;
   logic [W-1:0]  lo;
   logic [W-1:0]  dvs;
   logic [W-2:0]  q_sh;
   logic [CW-1:0] cnt;

   logic [W:0]    shifted;
   logic [W:0]    diff;
   logic          borrow_n;
   logic [W-1:0]  r_next;
   logic [W-1:0]  q_next;
   logic          last;
   logic          diff_msb_unused;

   assign shifted = {r, lo[W-1]};

   trial_subtractor #(.W(W)) u_sub (
      .minuend    (shifted),
      .subtrahend ({1'b0, dvs}),
      .difference (diff),
      .borrow_n   (borrow_n)
   );

   // A successful trial always leaves diff < divisor, so its MSB is zero.
   assign diff_msb_unused = diff[W];
   assign r_next = borrow_n ? diff[W-1:0] : shifted[W-1:0];
   assign q_next = {q_sh, borrow_n};
   assign last   = (cnt == CW'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
         r           <= '0;
         lo          <= '0;
         dvs         <= '0;
         q_sh        <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  cnt  <= '0;
                  r    <= dividend[2*W-1:W];
                  lo   <= dividend[W-1:0];
                  dvs  <= divisor;
                  q_sh <= '0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend[W-1:0];
                     div_by_zero <= 1'b1;
                     overflow    <= 1'b0;
                     state       <= DONE;
                  end else if (dividend[2*W-1:W] >= divisor) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b0;
                     overflow    <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               r    <= r_next;
               q_sh <= q_next[W-2:0];
               lo   <= {lo[W-2:0], 1'b0};
               cnt  <= cnt + 1'b1;
               if (last) begin
                  quotient    <= q_next;
                  remainder   <= r_next;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: begin
               // done is a registered output, so it is visible the cycle after DONE
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider_8x8.sv
// Scoreboard bench for seq_divider_8x8: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_seq_divider_8x8;
   import vedic_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [7:0]  divisor = '0;
   logic        busy, done, div_by_zero, overflow;
   logic [7:0]  quotient, remainder;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [7:0]  q;
      logic [7:0]  r;
      logic        dbz;
      logic        ovf;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   seq_divider_8x8 #(.W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            e = sbq.pop_front();
            chk("quotient", 32'(quotient), 32'(e.q));
            chk("remainder", 32'(remainder), 32'(e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            if (!e.dbz && !e.ovf) begin
               chk("invariant", 32'(quotient) * 32'(e.dvs) + 32'(remainder), 32'(e.dvd));
               chk("rem_lt_div", 32'(remainder < e.dvs), 32'd1);
            end
         end
      end
   end

   // Waits for done; checks busy stayed high and the done edge offset from accept edge k.
   task automatic wait_done(input int k, input int lat);
      int n = 0;
      int busy_low = 0;
      forever begin
         @(negedge clk);
         n++;
         if (done === 1'b1) begin
            chk("latency", 32'(cyc - k), 32'(lat));
            chk("busy_low_at_done", 32'(busy), 32'd0);
            chk("busy_high_while_running", 32'(busy_low), 32'd0);
            break;
         end
         if (busy !== 1'b1) busy_low++;
         if (n > lat + 5) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done at +%0d (cycle %0d)", lat, cyc);
            break;
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic [7:0] q,
                        input logic [7:0] r, input logic dbz, input logic ovf, input int lat);
      int k;
      @(negedge clk);
      wait_idle();
      start = 1'b1;
      dividend = a;
      divisor = b;
      sbq.push_back(exp_t'{a, b, q, r, dbz, ovf});
      @(posedge clk);
      #1;
      k = cyc;
      start = 1'b0;
      wait_done(k, lat);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k;
      logic [7:0]  b, hi, lo8;
      logic [15:0] a;

      #12;
      chk("reset_outputs", {24'd0, busy, done, div_by_zero, overflow, 4'd0}, 32'd0);
      chk("reset_results", {16'd0, quotient, remainder}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(16'd1000, 8'd10, 8'd100, 8'd0, 1'b0, 1'b0, 9);
      issue(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9);
      issue(16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1);
      issue(16'h0A00, 8'h0A, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
      issue(16'd4321, 8'd99, 8'd43, 8'd64, 1'b0, 1'b0, 9);

      // Start pulse with new operands in the middle of a run must be ignored.
      @(negedge clk);
      wait_idle();
      start = 1'b1;
      dividend = 16'd1000;
      divisor = 8'd10;
      sbq.push_back(exp_t'{16'd1000, 8'd10, 8'd100, 8'd0, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      k = cyc;
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      dividend = 16'h1234;
      divisor = 8'h00;
      @(negedge clk);
      start = 1'b0;
      wait_done(k, 9);
      repeat (12) @(negedge clk);

      // Start held high: re-accepted on the first IDLE edge, next done 10 cycles later.
      wait_idle();
      start = 1'b1;
      dividend = 16'd4321;
      divisor = 8'd99;
      sbq.push_back(exp_t'{16'd4321, 8'd99, 8'd43, 8'd64, 1'b0, 1'b0});
      sbq.push_back(exp_t'{16'd4321, 8'd99, 8'd43, 8'd64, 1'b0, 1'b0});
      @(posedge clk);
      #1;
      k = cyc;
      wait_done(k, 9);
      wait_done(k, 19);
      start = 1'b0;
      repeat (12) @(negedge clk);

      // Asynchronous reset during iteration 5 aborts with no result.
      wait_idle();
      start = 1'b1;
      dividend = 16'd1000;
      divisor = 8'd10;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {24'd0, busy, done, div_by_zero, overflow, 4'd0}, 32'd0);
      chk("midreset_results", {16'd0, quotient, remainder}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      issue(16'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0, 9);

      for (int i = 0; i < 1000; i++) begin
         b   = 8'($urandom_range(1, 255));
         hi  = 8'($urandom_range(0, int'(b) - 1));
         lo8 = 8'($urandom_range(0, 255));
         a   = {hi, lo8};
         issue(a, b, 8'(a / 16'(b)), 8'(a % 16'(b)), 1'b0, 1'b0, 9);
      end

      repeat (15) @(negedge clk);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
